apb_req_master: RTL and testbench
=================================

Name: apb_req_master

Overview:
Upstream APB master that feeds sdr_ctrl_top. It accepts host read/write requests on a valid/ready interface and buffers them in a small FIFO. It converts each request into a single APB3 SETUP/ACCESS transfer on the controller's APB port, and returns read data or a write acknowledgement on a response valid/ready interface. It issues nothing until the SDRAM initialisation-done flag is high.

Parameters:
ADDR_W, 32, APB address width (paddr)
DATA_W, 32, APB data width (pwdata/prdata, req_wdata, rsp_rdata)
FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2
TIMEOUT_CYC, 64, ACCESS-phase cycle limit (used only with the optional feature)

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  reset, asynchronous, active-high
init_done  in  1  SDRAM init complete (sys_INIT_DONE from controller)
req_valid  in  1  host request valid
req_ready  out  1  FIFO not full
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_write  out  1  echo of request type
rsp_rdata  out  DATA_W  prdata for reads; 0 for writes
rsp_err  out  1  transfer timed out (0 when feature absent)
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready

Behaviour:
- Reset (async, preset=1): FIFO empty. State IDLE. All outputs 0, except req_ready=1 once preset deasserts.
- FIFO: push on req_valid&&req_ready. req_ready = !full, registered full flag; it stays low when full even if a pop occurs in the same cycle. Pushed entry is visible the cycle after the push edge. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE -> SETUP when FIFO non-empty && init_done. The FIFO entry is popped on this edge and latched into pwrite/paddr/pwdata.
- SETUP: psel=1, penable=0. Always -> ACCESS after exactly one cycle.
- ACCESS: psel=1, penable=1. Stays in ACCESS while pready=0.
- On pready=1 in ACCESS: capture prdata into rsp_rdata for a read, or 0 for a write. Set rsp_write and go to RESP.
- RESP: psel=penable=0, rsp_valid=1, and response fields are held stable until rsp_ready.
- On the rsp_ready edge: go to SETUP if FIFO non-empty && init_done, popping the next entry; otherwise go to IDLE.
- Latency: accept at edge 0 -> psel high after edge 1 -> penable after edge 2 -> rsp_valid after edge 3 (pready=1, empty pipeline).
- paddr/pwdata/pwrite hold their last values outside transfers.
- init_done falling mid-transfer: the current transfer and response complete; no new SETUP starts until init_done returns high.
- Only one transfer is outstanding; a new SETUP never starts while rsp_valid is pending.

Optional Feature:
APB_TIMEOUT_EN.
- Defined: a counter clears on SETUP entry and increments each ACCESS cycle. If it reaches TIMEOUT_CYC with pready still 0: psel/penable drop, the FSM goes to RESP with rsp_err=1 and rsp_rdata=0, and rsp_err clears on response handshake. pready=1 on the same cycle the limit is hit counts as success.
- Undefined: no counter; ACCESS waits indefinitely and rsp_err is tied to 0.

Decomposition:
- Package apb_master_pkg: FSM state enum (IDLE/SETUP/ACCESS/RESP), packed request struct {write, addr, wdata}, default width constants.
- Sub-module apb_req_fifo: synchronous FIFO of request structs with full/empty, async active-high reset on pointers.

Test Plan:
- Write addr 0x0000_0010, data 0xDEAD_BEEF, pready=1, rsp_ready=1 -> psel after edge 1, penable after edge 2, rsp_valid after edge 3 with rsp_write=1, rsp_rdata=0.
- Read addr 0x0000_0010, pready low 5 ACCESS cycles then high with prdata=0xDEAD_BEEF -> penable held 6 cycles, rsp_rdata=0xDEAD_BEEF.
- init_done=0, push 2 requests -> psel stays 0. Raise init_done -> both transfers issue in order.
- rsp_ready=0, push 6 back-to-back requests -> 5 accepted (1 in flight, 4 buffered), req_ready=0 on 6th. Pulse rsp_ready -> req_ready returns to 1 next cycle.
- Assert preset during ACCESS -> psel/penable/rsp_valid 0 immediately, FIFO empty, req_ready=1 after release.
- With APB_TIMEOUT_EN, pready held 0 -> after 64 ACCESS cycles psel drops, rsp_valid=1 with rsp_err=1, and the next request proceeds normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types for the APB request master: FSM states, request record, default widths.
// The timeout default exists only when APB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
package apb_master_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
`ifdef APB_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC_DEF = 64;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_req_fifo.sv
// Synchronous request FIFO with registered full/empty flags.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
`timescale 1ns/1ps
module apb_req_fifo
  import apb_master_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter type         T     = apb_req_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     pop_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Flags are registered from the next occupancy, so a push is visible one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == CNT_W'(0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/apb_req_master.sv
// Host request -> APB3 master: buffers requests, runs one SETUP/ACCESS transfer at a time
// and returns a response. Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
`timescale 1ns/1ps
module apb_req_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
`ifdef APB_TIMEOUT_EN
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`else
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
`endif
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              push_data;
  req_t              pop_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  apb_state_e        state_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]   to_cnt_q;
  logic              rsp_err_q;
`endif

  assign push_data = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = ~preset & ~fifo_full;

  apb_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk_i       (pclk),
    .rst_i       (preset),
    .push_i      (req_valid),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (pop_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // A transfer starts from IDLE, or directly out of RESP on the response handshake edge.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty && init_done) begin
      case (state_q)
        ST_IDLE: fifo_pop = 1'b1;
        ST_RESP: fifo_pop = rsp_ready;
        default: fifo_pop = 1'b0;
      endcase
    end else begin
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
        end
        ST_ACCESS: begin
          if (pready) begin
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= pwrite_q;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= pwrite_q;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
`else
          end else begin
            state_q <= ST_ACCESS;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // Popping overrides the IDLE/RESP decisions above with a fresh SETUP.
      if (fifo_pop) begin
        state_q   <= ST_SETUP;
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        pwrite_q  <= pop_data.write;
        paddr_q   <= pop_data.addr;
        pwdata_q  <= pop_data.wdata;
`ifdef APB_TIMEOUT_EN
        to_cnt_q  <= '0;
`endif
      end
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_apb_req_master;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        init_done = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        req_ready, rsp_valid, rsp_write, rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  apb_req_master dut (
    .pclk(pclk), .preset(preset), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending request queue plus the transfer currently on the bus.
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } mreq_t;

  mreq_t       mq[$];
  mreq_t       mcur;
  bit          m_sel, m_en, m_rv, m_rw, m_err, m_full;
  logic [31:0] m_rd;
  int          m_wait;

  always @(posedge pclk or posedge preset) begin
    bit accept;
    bit can_issue;
    if (preset) begin
      mq.delete();
      mcur = '0;
      m_sel = 1'b0; m_en = 1'b0; m_rv = 1'b0; m_rw = 1'b0; m_err = 1'b0; m_full = 1'b0;
      m_rd = 32'h0;
      m_wait = 0;
    end else begin
      accept    = req_valid && !m_full;
      can_issue = (mq.size() != 0) && init_done && ((!m_sel && !m_rv) || (m_rv && rsp_ready));
      if (m_sel && !m_en) begin
        m_en = 1'b1;
      end else if (m_sel && m_en) begin
        if (pready) begin
          m_sel = 1'b0; m_en = 1'b0; m_rv = 1'b1; m_err = 1'b0;
          m_rw = mcur.w;
          m_rd = mcur.w ? 32'h0 : prdata;
        end else begin
          m_wait++;
`ifdef APB_TIMEOUT_EN
          if (m_wait == TIMEOUT) begin
            m_sel = 1'b0; m_en = 1'b0; m_rv = 1'b1; m_err = 1'b1;
            m_rw = mcur.w;
            m_rd = 32'h0;
          end
`endif
        end
      end else if (m_rv && rsp_ready) begin
        m_rv = 1'b0;
        m_err = 1'b0;
      end
      if (can_issue) begin
        mcur = mq.pop_front();
        m_sel = 1'b1; m_en = 1'b0; m_wait = 0;
      end
      if (accept) mq.push_back('{req_write, req_addr, req_wdata});
      m_full = (mq.size() == DEPTH);
    end
  end

  always @(negedge pclk) begin
    chk("psel", 64'(psel), 64'(m_sel));
    chk("penable", 64'(penable), 64'(m_en));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    chk("req_ready", 64'(req_ready), 64'(!preset && !m_full));
    chk("pwrite", 64'(pwrite), 64'(mcur.w));
    chk("paddr", 64'(paddr), 64'(mcur.a));
    chk("pwdata", 64'(pwdata), 64'(mcur.d));
    chk("rsp_err", 64'(rsp_err), 64'(m_err));
    if (m_rv) begin
      chk("rsp_write", 64'(rsp_write), 64'(m_rw));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_setup(output logic [31:0] a, output bit ok);
    ok = 1'b0;
    a = 32'h0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (psel && !penable) begin
        ok = 1'b1;
        a = paddr;
      end
    end
  endtask

  initial begin
    int          pen_cnt;
    int          acc;
    bit          any_sel;
    bit          ok;
    logic [31:0] a;

    // Reset
    step(); step();
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    preset = 1'b0;
    #1;
    chk("rel_req_ready", 64'(req_ready), 64'd1);
    init_done = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
    step();

    // Single write, zero-wait
    push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    step();
    chk("t1_psel", 64'(psel), 64'd1);
    chk("t1_penable0", 64'(penable), 64'd0);
    chk("t1_paddr", 64'(paddr), 64'h10);
    chk("t1_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    step();
    chk("t1_penable1", 64'(penable), 64'd1);
    step();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_write", 64'(rsp_write), 64'd1);
    chk("t1_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("t1_psel_drop", 64'(psel), 64'd0);
    step();
    chk("t1_rsp_done", 64'(rsp_valid), 64'd0);

    // Read with five wait states
    pready = 1'b0;
    push(1'b0, 32'h0000_0010, 32'h0);
    step();
    chk("t2_setup", 64'(psel && !penable), 64'd1);
    pen_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (penable) pen_cnt++;
      if (i == 5) begin
        pready = 1'b1;
        prdata = 32'hDEAD_BEEF;
      end
    end
    step();
    chk("t2_pen_cycles", 64'(pen_cnt), 64'd6);
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    chk("t2_rsp_write", 64'(rsp_write), 64'd0);
    step();
    prdata = 32'h0;

    // Held off by init_done, then issued in order
    init_done = 1'b0;
    push(1'b1, 32'h0000_0100, 32'h0000_0011);
    push(1'b0, 32'h0000_0104, 32'h0);
    prdata = 32'h1234_5678;
    any_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      any_sel |= psel;
    end
    chk("t3_no_issue", 64'(any_sel), 64'd0);
    init_done = 1'b1;
    wait_setup(a, ok);
    chk("t3_first_ok", 64'(ok), 64'd1);
    chk("t3_first_addr", 64'(a), 64'h100);
    wait_setup(a, ok);
    chk("t3_second_ok", 64'(ok), 64'd1);
    chk("t3_second_addr", 64'(a), 64'h104);
    repeat (4) step();
    prdata = 32'h0;

    // Backpressure: 1 in flight + 4 buffered, 6th refused
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 32'h0000_0200 + 32'(4 * i);
      req_wdata = 32'(i);
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    chk("t4_accepted", 64'(acc), 64'd5);
    chk("t4_full", 64'(req_ready), 64'd0);
    chk("t4_rsp_pending", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t4_ready_back", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    repeat (30) step();
    chk("t4_drained_psel", 64'(psel), 64'd0);
    chk("t4_drained_rsp", 64'(rsp_valid), 64'd0);

    // Reset during ACCESS
    pready = 1'b0;
    push(1'b0, 32'h0000_0300, 32'h0);
    push(1'b1, 32'h0000_0304, 32'h0000_0055);
    step();
    chk("t5_in_access", 64'(penable), 64'd1);
    preset = 1'b1;
    #1;
    chk("t5_psel", 64'(psel), 64'd0);
    chk("t5_penable", 64'(penable), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    preset = 1'b0;
    pready = 1'b1;
    #1;
    chk("t5_req_ready", 64'(req_ready), 64'd1);
    any_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      any_sel |= psel;
    end
    chk("t5_fifo_empty", 64'(any_sel), 64'd0);

`ifdef APB_TIMEOUT_EN
    // ACCESS timeout, then a normal transfer
    pready = 1'b0;
    rsp_ready = 1'b0;
    push(1'b0, 32'h0000_0400, 32'h0);
    pen_cnt = 0;
    for (int i = 0; i < 200 && !rsp_valid; i++) begin
      step();
      if (penable) pen_cnt++;
    end
    chk("t6_pen_cycles", 64'(pen_cnt), 64'(TIMEOUT));
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t6_rsp_err", 64'(rsp_err), 64'd1);
    chk("t6_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("t6_psel", 64'(psel), 64'd0);
    rsp_ready = 1'b1;
    pready = 1'b1;
    step();
    chk("t6_err_clear", 64'(rsp_err), 64'd0);
    push(1'b1, 32'h0000_0404, 32'h0000_00AA);
    wait_setup(a, ok);
    chk("t6_next_addr", 64'(a), 64'h404);
    repeat (4) step();
    chk("t6_next_done", 64'(rsp_valid || psel), 64'd0);
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
